// File: rtl/mmio_interconnect_if.sv
// CPU-to-slave MMIO bus bundle: CPU request/response, per-slave strobes and
// read data, and the unmapped-write error reporting signals.
interface mmio_interconnect_if #(
  parameter int NUM_SLAVES = 3
);
  logic [31:0]              memAddress;
  logic                     memWrite;
  logic [31:0]              memReadData;
  logic [NUM_SLAVES-1:0]    slvMemWrite;
  logic [NUM_SLAVES-1:0]    slvSel;
  logic [NUM_SLAVES*32-1:0] slvReadData;
  logic                     errClear;
  logic                     errFlag;
  logic [31:0]              errAddr;

  // CPU and slave side: drives requests and slave read data
  modport master (
    output memAddress, memWrite, slvReadData, errClear,
    input  memReadData, slvMemWrite, slvSel, errFlag, errAddr
  );

  // Interconnect side
  modport slave (
    input  memAddress, memWrite, slvReadData, errClear,
    output memReadData, slvMemWrite, slvSel, errFlag, errAddr
  );
endinterface

// File: rtl/mmio_interconnect.sv
// Address-window MMIO decoder with one-cycle registered read mux.
// Optional sticky unmapped-write capture enabled by macro MMIO_ERR_CAPTURE_EN.
module mmio_interconnect #(
  parameter int                       NUM_SLAVES   = 3,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS   = {32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] TOP_ADDRS    = {32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'h0000_07FF},
  parameter logic [31:0]              DEFAULT_READ = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_interconnect_if.slave  bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_SLAVES-1:0] w_sel;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_hit;
  logic [31:0]           w_rd_data;
  logic [IDX_W-1:0]      r_sel_idx;
  logic                  r_hit;

  // Window decode; scanning from the top index down lets the lowest index win
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    w_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.memAddress >= BASE_ADDRS[32*i +: 32]) &&
          (bus.memAddress <= TOP_ADDRS[32*i +: 32])) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_idx    = IDX_W'(i);
        w_hit    = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign bus.slvSel      = w_sel;
  assign bus.slvMemWrite = w_sel & {NUM_SLAVES{bus.memWrite}};

  // Registers the winning slave for the next-cycle read return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_idx <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_sel_idx <= w_idx;
      r_hit     <= w_hit;
    end
  end

  // Read mux driven directly from the registered selection
  always_comb begin
    w_rd_data = DEFAULT_READ;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_rd_data = (r_hit && (r_sel_idx == IDX_W'(i))) ? bus.slvReadData[32*i +: 32] : w_rd_data;
    end
  end

  assign bus.memReadData = w_rd_data;

`ifdef MMIO_ERR_CAPTURE_EN
  logic        r_err_flag;
  logic [31:0] r_err_addr;

  // First unmapped write is held; a new one in the clear cycle takes precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_flag <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else if (bus.memWrite && !w_hit && (!r_err_flag || bus.errClear)) begin
      r_err_flag <= 1'b1;
      r_err_addr <= bus.memAddress;
    end else if (bus.errClear) begin
      r_err_flag <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else begin
      r_err_flag <= r_err_flag;
      r_err_addr <= r_err_addr;
    end
  end

  assign bus.errFlag = r_err_flag;
  assign bus.errAddr = r_err_addr;
`else
  logic w_unused_err_clear;
  assign w_unused_err_clear = bus.errClear;
  assign bus.errFlag        = 1'b0;
  assign bus.errAddr        = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed self-checking bench for mmio_interconnect (default and overlap configs).
module tb_mmio_interconnect;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  localparam logic [31:0] S0 = 32'hDEAD_BEEF;
  localparam logic [31:0] S1 = 32'hB0B0_0001;
  localparam logic [31:0] S2 = 32'hC0DE_0002;

  mmio_interconnect_if #(.NUM_SLAVES(3)) dut_if ();
  mmio_interconnect_if #(.NUM_SLAVES(3)) ovl_if ();

  mmio_interconnect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  mmio_interconnect #(
    .NUM_SLAVES (3),
    .BASE_ADDRS ({32'hFFFF_FFF4, 32'h0000_0000, 32'h0000_0000}),
    .TOP_ADDRS  ({32'hFFFF_FFFF, 32'hFFFF_FFF3, 32'h0000_07FF})
  ) dut_ovl (
    .clk   (clk),
    .reset (reset),
    .bus   (ovl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic wr, input logic clr);
    dut_if.memAddress = addr;
    dut_if.memWrite   = wr;
    dut_if.errClear   = clr;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    dut_if.slvReadData = {S2, S1, S0};
    ovl_if.slvReadData = {S2, S1, S0};
    ovl_if.memAddress  = 32'h0;
    ovl_if.memWrite    = 1'b0;
    ovl_if.errClear    = 1'b0;
    drive(32'h0000_0100, 1'b0, 1'b0);
    cyc();
    cyc();
    check_val("rst_rdata", dut_if.memReadData, 32'h0);
    check_val("rst_errflag", {31'h0, dut_if.errFlag}, 32'h0);
    check_val("rst_erraddr", dut_if.errAddr, 32'h0);
    reset = 1'b0;

    // Single read of slave 0
    drive(32'h0000_0100, 1'b0, 1'b0);
    check_val("sel_s0", {29'h0, dut_if.slvSel}, 32'h1);
    cyc();
    check_val("rd_s0", dut_if.memReadData, S0);

    // Back-to-back slave1 then slave2
    drive(32'hFFFF_FFF0, 1'b0, 1'b0);
    check_val("sel_s1", {29'h0, dut_if.slvSel}, 32'h2);
    cyc();
    check_val("rd_s1", dut_if.memReadData, S1);
    drive(32'hFFFF_FFF4, 1'b0, 1'b0);
    check_val("sel_s2", {29'h0, dut_if.slvSel}, 32'h4);
    cyc();
    check_val("rd_s2", dut_if.memReadData, S2);

    // Mapped write strobe, and window edges
    drive(32'h0000_07FF, 1'b1, 1'b0);
    check_val("wr_s0_top", {29'h0, dut_if.slvMemWrite}, 32'h1);
    drive(32'hFFFF_FFF7, 1'b0, 1'b0);
    check_val("sel_s2_top", {29'h0, dut_if.slvSel}, 32'h4);
    check_val("nowr_s2", {29'h0, dut_if.slvMemWrite}, 32'h0);
    drive(32'hFFFF_FFFF, 1'b0, 1'b0);
    check_val("sel_ffff_miss", {29'h0, dut_if.slvSel}, 32'h0);
    ovl_if.memAddress = 32'hFFFF_FFFF;
    #1;
    check_val("ovl_sel_ffff", {29'h0, ovl_if.slvSel}, 32'h4);
    cyc();
    check_val("rd_miss_ffff", dut_if.memReadData, 32'h0);

    // Unmapped write
    drive(32'h0000_0800, 1'b1, 1'b0);
    check_val("wr_miss_strobe", {29'h0, dut_if.slvMemWrite}, 32'h0);
    check_val("wr_miss_sel", {29'h0, dut_if.slvSel}, 32'h0);
    cyc();
    check_val("rd_miss", dut_if.memReadData, 32'h0);
`ifdef MMIO_ERR_CAPTURE_EN
    check_val("err1_flag", {31'h0, dut_if.errFlag}, 32'h1);
    check_val("err1_addr", dut_if.errAddr, 32'h0000_0800);
`else
    check_val("err1_flag", {31'h0, dut_if.errFlag}, 32'h0);
    check_val("err1_addr", dut_if.errAddr, 32'h0);
`endif

    // Second error is not captured; clear with simultaneous error takes the new one
    drive(32'h1000_0000, 1'b1, 1'b0);
    cyc();
    drive(32'h2000_0000, 1'b1, 1'b1);
`ifdef MMIO_ERR_CAPTURE_EN
    check_val("err2_hold", dut_if.errAddr, 32'h0000_0800);
`else
    check_val("err2_hold", dut_if.errAddr, 32'h0);
`endif
    cyc();
`ifdef MMIO_ERR_CAPTURE_EN
    check_val("errclr_new_flag", {31'h0, dut_if.errFlag}, 32'h1);
    check_val("errclr_new_addr", dut_if.errAddr, 32'h2000_0000);
`else
    check_val("errclr_new_flag", {31'h0, dut_if.errFlag}, 32'h0);
    check_val("errclr_new_addr", dut_if.errAddr, 32'h0);
`endif
    drive(32'h0000_0100, 1'b0, 1'b1);
    cyc();
    check_val("errclr_flag", {31'h0, dut_if.errFlag}, 32'h0);
    check_val("errclr_addr", dut_if.errAddr, 32'h0);
    check_val("rd_after_clr", dut_if.memReadData, S0);

    // Reset during a mapped write
    reset = 1'b1;
    drive(32'hFFFF_FFF0, 1'b1, 1'b0);
    check_val("rst_wr_strobe", {29'h0, dut_if.slvMemWrite}, 32'h2);
    cyc();
    check_val("rst_wr_rdata", dut_if.memReadData, 32'h0);
    check_val("rst_wr_flag", {31'h0, dut_if.errFlag}, 32'h0);
    reset = 1'b0;

    // Reset overrides an unmapped-write capture in the same cycle
    drive(32'h0000_0800, 1'b1, 1'b0);
    cyc();
    reset = 1'b1;
    drive(32'h3000_0000, 1'b1, 1'b0);
    cyc();
    check_val("rst_ovr_flag", {31'h0, dut_if.errFlag}, 32'h0);
    check_val("rst_ovr_addr", dut_if.errAddr, 32'h0);
    reset = 1'b0;
    drive(32'h0000_0100, 1'b0, 1'b0);

    // Overlapping windows: lowest index wins
    ovl_if.memAddress = 32'h0000_0000;
    #1;
    check_val("ovl_sel_0", {29'h0, ovl_if.slvSel}, 32'h1);
    cyc();
    check_val("ovl_rd_0", ovl_if.memReadData, S0);
    ovl_if.memAddress = 32'h0000_0800;
    #1;
    check_val("ovl_sel_800", {29'h0, ovl_if.slvSel}, 32'h2);
    cyc();
    check_val("ovl_rd_800", ovl_if.memReadData, S1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_interconnect.md
MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_SLAVES, default 3: number of slave channels, range 1..16.
REQ-003 Parameter BASE_ADDRS, default {32'hFFFF_FFF4, 32'hFFFF_FFF0, 32'h0000_0000}: packed NUM_SLAVES*32 inclusive base addresses, slave i at bits [32i+31:32i].
REQ-004 Parameter TOP_ADDRS, default {32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'h0000_07FF}: packed inclusive top addresses, same packing.
REQ-005 Parameter DEFAULT_READ, default 32'h0000_0000: read data returned on a miss.
REQ-006 clk  input  1  system clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 memAddress  input  32  CPU byte address, valid every cycle.
REQ-009 memWrite  input  1  CPU write strobe, one cycle per write.
REQ-010 memReadData  output  32  read data returned to CPU.
REQ-011 slvMemWrite  output  NUM_SLAVES  per-slave gated write strobe.
REQ-012 slvSel  output  NUM_SLAVES  one-hot combinational address-hit vector.
REQ-013 slvReadData  input  NUM_SLAVES*32  packed slave read data, slave i at [32i+31:32i].
REQ-014 errClear  input  1  clears captured error state.
REQ-015 errFlag  output  1  sticky unmapped-write flag.
REQ-016 errAddr  output  32  address of first unmapped write since last clear.

Function
REQ-017 Decode SHALL be combinational: slave i hits when BASE_i <= memAddress <= TOP_i, unsigned 32-bit compare.
REQ-018 On overlapping windows the lowest index SHALL win; slvSel SHALL be strictly one-hot or all-zero.
REQ-019 slvMemWrite[i] SHALL equal memWrite AND slvSel[i], same cycle, no latency.
REQ-020 The block SHALL register the winning index and a hit bit every cycle (selIdx_q, hit_q).
REQ-021 memReadData SHALL equal slave selIdx_q read data when hit_q=1, else DEFAULT_READ; read latency is exactly one cycle after the address.
REQ-022 The read mux SHALL be combinational from selIdx_q/hit_q and slvReadData, with no extra register stage.
REQ-023 A write with memWrite=1 and no hit SHALL drive all slvMemWrite low.
REQ-024 Back-to-back accesses to different slaves SHALL each return the correct slave's data one cycle later, no bubbles.
REQ-025 Address 32'hFFFF_FFFF SHALL decode normally, with no compare overflow.

Reset
REQ-026 On reset: hit_q=0, selIdx_q=0, errFlag=0, errAddr=32'h0; memReadData=DEFAULT_READ the cycle after reset.
REQ-027 Reset asserted mid-access SHALL override any concurrent write error capture in that cycle.
REQ-028 slvSel and slvMemWrite SHALL remain combinational during reset; slaves handle their own reset.

Configuration
REQ-029 Macro MMIO_ERR_CAPTURE_EN defined: unmapped write sets errFlag and latches errAddr only if errFlag was 0, so the first error is held.
REQ-030 With MMIO_ERR_CAPTURE_EN defined: errClear=1 clears errFlag and errAddr next cycle; a simultaneous new unmapped write SHALL win and set errFlag with its address.
REQ-031 Macro MMIO_ERR_CAPTURE_EN undefined: errFlag tied 0, errAddr tied 32'h0, errClear ignored, no error registers instantiated.

Verification
REQ-032 Read 32'h0000_0100, slave0 data 32'hDEAD_BEEF -> slvSel=3'b001 same cycle, memReadData=32'hDEAD_BEEF next cycle.
REQ-033 Addresses 32'hFFFF_FFF0 then 32'hFFFF_FFF4 on consecutive cycles -> memReadData returns slave1 data then slave2 data, each one cycle late.
REQ-034 Write to 32'h0000_0800 -> slvMemWrite=3'b000, memReadData=32'h0 next cycle; with MMIO_ERR_CAPTURE_EN, errFlag=1 and errAddr=32'h0000_0800.
REQ-035 Second unmapped write to 32'h1000_0000 -> errAddr stays 32'h0000_0800; errClear plus unmapped write to 32'h2000_0000 in the same cycle -> errFlag=1, errAddr=32'h2000_0000.
REQ-036 Reset during a write to 32'hFFFF_FFF0 -> memReadData=32'h0 and errFlag=0 next cycle; slvMemWrite=3'b010 during that cycle.
REQ-037 Overlap config BASE1=32'h0000_0000 -> address 32'h0 selects slave0 only, slvSel=3'b001.
